// File: rtl/axi_lite_reg_bank_if.sv
// ---------------------------------------------------------------------------
// axi_lite_if
// Purpose : AXI-Lite bus bundle shared by a manager and a subordinate.
// Ports   : none; the five channels are grouped as signals.
//   AW : awvalid/awready, awid, awaddr, awprot
//   W  : wvalid/wready, wdata, wstrb
//   B  : bvalid/bready, bid, bresp
//   AR : arvalid/arready, arid, araddr, arprot
//   R  : rvalid/rready, rid, rdata, rresp
// Modports: master drives requests, slave drives ready/response signals.
// ---------------------------------------------------------------------------
interface axi_lite_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, arid, araddr, arprot, rready,
    input  awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
  );

  modport slave (
    input  awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, arid, araddr, arprot, rready,
    output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_bank
// Purpose : AXI-Lite subordinate holding NUM_REGS DATA_WIDTH-bit registers
//           with byte strobes, ID echo and SLVERR decode. AW and W are held
//           in independent one-deep stages; reads run concurrently.
// Ports   :
//   aclk        : clock
//   aresetn     : asynchronous active-low reset
//   s_axil      : axi_lite_if.slave bus port
//   reg_o       : flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   hw_status_i : status words returned by reads of read-only registers
// Optional feature macro: AXIL_REG_BANK_PROT_CHECK_EN
//   When defined, any access with prot[0]=0 (unprivileged) gets SLVERR,
//   writes nothing and reads return zero. When undefined prot is ignored.
// ---------------------------------------------------------------------------
module axi_lite_reg_bank #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axi_lite_if.slave                      s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i
);
  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WA_W     = ADDR_WIDTH - ADDR_LSB;

  logic                  r_awFull;
  logic [ID_WIDTH-1:0]   r_awId;
  logic [WA_W-1:0]       r_awWord;
  logic [2:0]            r_awProt;
  logic                  r_wFull;
  logic [DATA_WIDTH-1:0] r_wData;
  logic [STRB_WIDTH-1:0] r_wStrb;
  logic                  r_bValid;
  logic [ID_WIDTH-1:0]   r_bId;
  logic [1:0]            r_bResp;
  logic                  r_rValid;
  logic [ID_WIDTH-1:0]   r_rId;
  logic [DATA_WIDTH-1:0] r_rData;
  logic [1:0]            r_rResp;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_awHs, w_wHs, w_arHs, w_arReady, w_commit;
  logic [IDX_W-1:0]      w_awIdx, w_arIdx;
  logic [WA_W-1:0]       w_arWord;
  logic                  w_awInRange, w_arInRange, w_awRo, w_arRo;
  logic                  w_awProtErr, w_arProtErr, w_awErr, w_arErr;
  logic [DATA_WIDTH-1:0] w_arData;
  logic                  w_unusedBits;

  assign s_axil.awready = !r_awFull;
  assign s_axil.wready  = !r_wFull;
  assign s_axil.bvalid  = r_bValid;
  assign s_axil.bid     = r_bId;
  assign s_axil.bresp   = r_bResp;
  assign s_axil.rvalid  = r_rValid;
  assign s_axil.rid     = r_rId;
  assign s_axil.rdata   = r_rData;
  assign s_axil.rresp   = r_rResp;
  assign s_axil.arready = w_arReady;

  assign w_arReady = !r_rValid || s_axil.rready;
  assign w_awHs    = s_axil.awvalid && !r_awFull;
  assign w_wHs     = s_axil.wvalid && !r_wFull;
  assign w_arHs    = s_axil.arvalid && w_arReady;
  // A write commits only when both halves are held and the B slot is free.
  assign w_commit  = r_awFull && r_wFull && (!r_bValid || s_axil.bready);

  // The whole word address takes part in the range check, so an address
  // past the last register is flagged instead of aliasing onto a low index.
  assign w_arWord    = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_awIdx     = r_awWord[IDX_W-1:0];
  assign w_arIdx     = w_arWord[IDX_W-1:0];
  assign w_awInRange = (r_awWord < WA_W'(NUM_REGS));
  assign w_arInRange = (w_arWord < WA_W'(NUM_REGS));
  assign w_awRo      = w_awInRange && RO_MASK[w_awIdx];
  assign w_arRo      = w_arInRange && RO_MASK[w_arIdx];

`ifdef AXIL_REG_BANK_PROT_CHECK_EN
  assign w_awProtErr = !r_awProt[0];
  assign w_arProtErr = !s_axil.arprot[0];
`else
  assign w_awProtErr = 1'b0;
  assign w_arProtErr = 1'b0;
`endif

  assign w_awErr = !w_awInRange || w_awRo || w_awProtErr;
  assign w_arErr = !w_arInRange || w_arProtErr;
  assign w_unusedBits = ^{r_awProt, s_axil.arprot,
                          s_axil.awaddr[ADDR_LSB-1:0], s_axil.araddr[ADDR_LSB-1:0]};

  // Read data mux: read-only slots return live hardware status, writable
  // slots return stored contents, anything rejected returns zero.
  always_comb begin
    w_arData = '0;
    if (w_arInRange && !w_arProtErr) begin
      if (w_arRo) w_arData = hw_status_i[w_arIdx*DATA_WIDTH +: DATA_WIDTH];
      else        w_arData = r_regs[w_arIdx];
    end
  end

  // AW holding stage: fills on handshake, empties when the write commits.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awFull <= 1'b0;
      r_awId   <= '0;
      r_awWord <= '0;
      r_awProt <= '0;
    end else if (w_awHs) begin
      r_awFull <= 1'b1;
      r_awId   <= s_axil.awid;
      r_awWord <= s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
      r_awProt <= s_axil.awprot;
    end else if (w_commit) begin
      r_awFull <= 1'b0;
    end
  end

  // W holding stage: independent of AW so data may arrive first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wFull <= 1'b0;
      r_wData <= '0;
      r_wStrb <= '0;
    end else if (w_wHs) begin
      r_wFull <= 1'b1;
      r_wData <= s_axil.wdata;
      r_wStrb <= s_axil.wstrb;
    end else if (w_commit) begin
      r_wFull <= 1'b0;
    end
  end

  // Register storage: byte-wise update on a commit that decoded cleanly.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && !w_awErr) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (r_wStrb[b]) r_regs[w_awIdx][b*8 +: 8] <= r_wData[b*8 +: 8];
      end
    end
  end

  // Write response: loaded on commit, held until the manager takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bValid <= 1'b0;
      r_bId    <= '0;
      r_bResp  <= 2'b00;
    end else if (w_commit) begin
      r_bValid <= 1'b1;
      r_bId    <= r_awId;
      r_bResp  <= w_awErr ? 2'b10 : 2'b00;
    end else if (s_axil.bready) begin
      r_bValid <= 1'b0;
    end
  end

  // Read response: sampled from pre-edge register state, so a same-edge
  // write commit is not visible to the read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rValid <= 1'b0;
      r_rId    <= '0;
      r_rData  <= '0;
      r_rResp  <= 2'b00;
    end else if (w_arHs) begin
      r_rValid <= 1'b1;
      r_rId    <= s_axil.arid;
      r_rData  <= w_arData;
      r_rResp  <= w_arErr ? 2'b10 : 2'b00;
    end else if (s_axil.rready) begin
      r_rValid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regOut
    assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
  end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_reg_bank
// Purpose : directed, table-driven bench for axi_lite_reg_bank with 16
//           registers, register 3 read-only, 2-bit IDs.
// ---------------------------------------------------------------------------
module tb_axi_lite_reg_bank;
  logic aclk = 1'b0;
  logic aresetn;
  logic [16*32-1:0] regO;
  logic [16*32-1:0] hwStatus;
  int errorCount = 0;
  int checkCount = 0;

  axi_lite_if #(.ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_reg_bank #(
    .ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
    .RO_MASK(16'h0008)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axil(bus.slave),
    .reg_o(regO), .hw_status_i(hwStatus)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  expBresp;
    logic [31:0] expRdata;
    logic [1:0]  expRresp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] regAt(input int i);
    return regO[i*32 +: 32];
  endfunction

  // Every comparison goes through here so the counters stay consistent.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendAw(input logic [31:0] addr, input logic [1:0] id, input logic [2:0] prot);
    logic ok = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id; bus.awprot = prot;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk); ok = bus.awready;
      @(posedge aclk); #1;
      if (ok) break;
    end
    bus.awvalid = 1'b0;
    checkOutput("awHandshake", {63'b0, ok}, 64'd1);
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
    logic ok = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk); ok = bus.wready;
      @(posedge aclk); #1;
      if (ok) break;
    end
    bus.wvalid = 1'b0;
    checkOutput("wHandshake", {63'b0, ok}, 64'd1);
  endtask

  task automatic sendAr(input logic [31:0] addr, input logic [1:0] id, input logic [2:0] prot);
    logic ok = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id; bus.arprot = prot;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk); ok = bus.arready;
      @(posedge aclk); #1;
      if (ok) break;
    end
    bus.arvalid = 1'b0;
    checkOutput("arHandshake", {63'b0, ok}, 64'd1);
  endtask

  task automatic waitB(output logic [1:0] resp, output logic [1:0] id);
    logic ok = 1'b0;
    resp = 2'bxx; id = 2'bxx;
    bus.bready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk); ok = bus.bvalid; resp = bus.bresp; id = bus.bid;
      @(posedge aclk); #1;
      if (ok) break;
    end
    bus.bready = 1'b0;
    checkOutput("bArrived", {63'b0, ok}, 64'd1);
  endtask

  task automatic waitR(output logic [31:0] data, output logic [1:0] resp, output logic [1:0] id);
    logic ok = 1'b0;
    data = 'x; resp = 2'bxx; id = 2'bxx;
    bus.rready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk); ok = bus.rvalid; data = bus.rdata; resp = bus.rresp; id = bus.rid;
      @(posedge aclk); #1;
      if (ok) break;
    end
    bus.rready = 1'b0;
    checkOutput("rArrived", {63'b0, ok}, 64'd1);
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] id, input logic [2:0] prot,
                         output logic [1:0] resp, output logic [1:0] bidOut);
    fork
      sendAw(addr, id, prot);
      sendW(data, strb);
    join
    waitB(resp, bidOut);
  endtask

  task automatic doRead(input logic [31:0] addr, input logic [1:0] id, input logic [2:0] prot,
                        output logic [31:0] data, output logic [1:0] resp, output logic [1:0] ridOut);
    sendAr(addr, id, prot);
    waitR(data, resp, ridOut);
  endtask

  // One table row: write, check B, read back, check R.
  task automatic applyStimulus(input int n);
    logic [1:0]  resp, idOut;
    logic [31:0] data;
    logic [1:0]  id = n[1:0];
    doWrite(vecs[n].addr, vecs[n].wdata, vecs[n].strb, id, 3'b001, resp, idOut);
    checkOutput($sformatf("vec%0d bresp", n), {62'b0, resp}, {62'b0, vecs[n].expBresp});
    checkOutput($sformatf("vec%0d bid", n), {62'b0, idOut}, {62'b0, id});
    doRead(vecs[n].addr, ~id, 3'b001, data, resp, idOut);
    checkOutput($sformatf("vec%0d rdata", n), {32'b0, data}, {32'b0, vecs[n].expRdata});
    checkOutput($sformatf("vec%0d rresp", n), {62'b0, resp}, {62'b0, vecs[n].expRresp});
    checkOutput($sformatf("vec%0d rid", n), {62'b0, idOut}, {62'b0, ~id});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  resp, idOut;
    logic [31:0] data;
    logic [31:0] expRegs [16];

    for (int i = 0; i < 16; i++) hwStatus[i*32 +: 32] = 32'hA0A0_0000 | i;
    hwStatus[3*32 +: 32] = 32'h0000_5A5A;

    vecs[0] = '{32'h10, 32'h0102_0304, 4'hF, 2'b00, 32'h0102_0304, 2'b00};
    vecs[1] = '{32'h04, 32'h1234_5678, 4'hF, 2'b00, 32'h1234_5678, 2'b00};
    vecs[2] = '{32'h07, 32'hAABB_CCDD, 4'h8, 2'b00, 32'hAA34_5678, 2'b00};
    vecs[3] = '{32'h0C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_5A5A, 2'b00};
    vecs[4] = '{32'h50, 32'h1234_5678, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vecs[5] = '{32'h3C, 32'hCAFE_F00D, 4'h3, 2'b00, 32'h0000_F00D, 2'b00};
    vecs[6] = '{32'h40, 32'h7777_7777, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vecs[7] = '{32'h0A, 32'h9999_9999, 4'h0, 2'b00, 32'hDEAD_BEEF, 2'b00};

    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    $display("[TB] reset state");
    checkOutput("rstReady", {62'b0, bus.awready, bus.wready}, 64'd3);
    checkOutput("rstValids", {62'b0, bus.bvalid, bus.rvalid}, 64'd0);
    checkOutput("rstRegsZero", {63'b0, |regO}, 64'd0);

    $display("[TB] write latency, reg 2");
    bus.awvalid = 1; bus.awaddr = 32'h08; bus.awid = 2'd1; bus.awprot = 3'b001;
    bus.wvalid = 1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    @(posedge aclk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    checkOutput("latBvalidEarly", {63'b0, bus.bvalid}, 64'd0);
    checkOutput("latAwHeld", {63'b0, bus.awready}, 64'd0);
    @(posedge aclk); #1;
    checkOutput("latBvalid", {63'b0, bus.bvalid}, 64'd1);
    checkOutput("latBid", {62'b0, bus.bid}, 64'd1);
    checkOutput("latBresp", {62'b0, bus.bresp}, 64'd0);
    checkOutput("latReg2", {32'b0, regAt(2)}, 64'hDEAD_BEEF);
    bus.bready = 1;
    @(posedge aclk); #1;
    bus.bready = 0;
    checkOutput("latBdone", {63'b0, bus.bvalid}, 64'd0);

    $display("[TB] vector table");
    for (int n = 0; n < 8; n++) applyStimulus(n);
    for (int i = 0; i < 16; i++) expRegs[i] = 32'h0;
    expRegs[1] = 32'hAA34_5678; expRegs[2] = 32'hDEAD_BEEF;
    expRegs[4] = 32'h0102_0304; expRegs[15] = 32'h0000_F00D;
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("tableReg%0d", i), {32'b0, regAt(i)}, {32'b0, expRegs[i]});

    $display("[TB] W before AW, reg 0");
    bus.wvalid = 1; bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101;
    @(posedge aclk); #1;
    bus.wvalid = 0;
    checkOutput("wFirstHeld", {62'b0, bus.wready, bus.awready}, 64'd1);
    repeat (2) @(posedge aclk);
    #1 checkOutput("wFirstNoB", {63'b0, bus.bvalid}, 64'd0);
    sendAw(32'h00, 2'd2, 3'b001);
    waitB(resp, idOut);
    checkOutput("wFirstBresp", {62'b0, resp}, 64'd0);
    checkOutput("wFirstBid", {62'b0, idOut}, 64'd2);
    checkOutput("wFirstReg0", {32'b0, regAt(0)}, 64'h0022_0044);

    $display("[TB] backpressure and same-edge read");
    fork sendAw(32'h14, 2'd3, 3'b001); sendW(32'h5555_5555, 4'hF); join
    @(posedge aclk); #1;
    sendAr(32'h08, 2'd1, 3'b001);
    fork sendAw(32'h04, 2'd0, 3'b001); sendW(32'h1111_1111, 4'hF); join
    for (int c = 0; c < 5; c++) begin
      checkOutput("holdB", {59'b0, bus.bvalid, bus.bid, bus.bresp}, {59'b0, 1'b1, 2'd3, 2'b00});
      checkOutput("holdR", {29'b0, bus.rvalid, bus.rid, bus.rresp, bus.rdata},
                  {29'b0, 1'b1, 2'd1, 2'b00, 32'hDEAD_BEEF});
      checkOutput("holdReady", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd0);
      checkOutput("holdReg1", {32'b0, regAt(1)}, 64'hAA34_5678);
      @(posedge aclk); #1;
    end
    bus.bready = 1; bus.rready = 1;
    bus.arvalid = 1; bus.araddr = 32'h04; bus.arid = 2'd2; bus.arprot = 3'b001;
    @(posedge aclk); #1;
    bus.bready = 0; bus.rready = 0; bus.arvalid = 0;
    checkOutput("sameEdgeR", {29'b0, bus.rvalid, bus.rid, bus.rresp, bus.rdata},
                {29'b0, 1'b1, 2'd2, 2'b00, 32'hAA34_5678});
    checkOutput("sameEdgeB", {59'b0, bus.bvalid, bus.bid, bus.bresp}, {59'b0, 1'b1, 2'd0, 2'b00});
    checkOutput("sameEdgeReg1", {32'b0, regAt(1)}, 64'h1111_1111);
    checkOutput("sameEdgeReg5", {32'b0, regAt(5)}, 64'h5555_5555);
    waitB(resp, idOut);
    waitR(data, resp, idOut);

    $display("[TB] reset with traffic pending");
    sendAr(32'h04, 2'd1, 3'b001);
    bus.awvalid = 1; bus.awaddr = 32'h08; bus.awid = 2'd1; bus.awprot = 3'b001;
    @(posedge aclk); #1;
    checkOutput("preRstAwFull", {62'b0, bus.awready, bus.rvalid}, 64'd1);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("asyncRstValids", {62'b0, bus.bvalid, bus.rvalid}, 64'd0);
    checkOutput("asyncRstReady", {62'b0, bus.awready, bus.wready}, 64'd3);
    checkOutput("asyncRstRegs", {63'b0, |regO}, 64'd0);
    bus.awvalid = 0;
    @(posedge aclk); #1 aresetn = 1'b1;
    sendW(32'h0BAD_F00D, 4'hF);
    repeat (3) @(posedge aclk);
    #1 checkOutput("rstDroppedAw", {63'b0, bus.bvalid}, 64'd0);
    sendAw(32'h08, 2'd3, 3'b001);
    waitB(resp, idOut);
    checkOutput("postRstBresp", {62'b0, resp}, 64'd0);
    checkOutput("postRstReg2", {32'b0, regAt(2)}, 64'h0BAD_F00D);

    $display("[TB] unprivileged access");
    doRead(32'h08, 2'd1, 3'b000, data, resp, idOut);
`ifdef AXIL_REG_BANK_PROT_CHECK_EN
    checkOutput("protRresp", {62'b0, resp}, 64'd2);
    checkOutput("protRdata", {32'b0, data}, 64'd0);
    doWrite(32'h08, 32'h1234_0000, 4'hF, 2'd1, 3'b000, resp, idOut);
    checkOutput("protBresp", {62'b0, resp}, 64'd2);
    checkOutput("protReg2", {32'b0, regAt(2)}, 64'h0BAD_F00D);
`else
    checkOutput("protRresp", {62'b0, resp}, 64'd0);
    checkOutput("protRdata", {32'b0, data}, 64'h0BAD_F00D);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
